// File: rtl/cpu_clk_en_sched.sv
// Clock-enable scheduler: one-cycle strobe every cur_div master cycles,
// with run-time ratio changes applied only at a period boundary.
module cpu_clk_en_sched #(
    parameter int DIV_W   = 4,
    parameter int DEF_DIV = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_sel,
    output logic             div_ack,
    input  logic             stall,
    output logic             clk_en,
    output logic [DIV_W-1:0] cur_div,
    output logic [DIV_W-1:0] phase,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_DONE
    } state_t;

    localparam logic [DIV_W-1:0] LP_DEF = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] LP_ONE = DIV_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_cur_div;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] w_sel_clamped;
    logic             r_clk_en;
    logic             r_ack;
    logic             r_busy;
    logic             w_term;

    assign w_term        = (r_cnt == r_cur_div - LP_ONE) && !stall;
    assign w_sel_clamped = (div_sel == '0) ? LP_ONE : div_sel;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (div_req) w_state_nxt = S_PEND;
            S_PEND:  if (w_term) w_state_nxt = S_DONE;
            S_DONE:  if (!div_req) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ack/busy are registered from the next state so they track it exactly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_clk_en   <= 1'b0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_cur_div  <= LP_DEF;
            r_pend_div <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_clk_en <= w_term;
            r_ack    <= (w_state_nxt == S_DONE);
            r_busy   <= (w_state_nxt != S_IDLE);
            if (w_term) begin
                r_cnt <= '0;
            end else if (!stall) begin
                r_cnt <= r_cnt + LP_ONE;
            end
            if (r_state == S_IDLE && div_req) begin
                r_pend_div <= w_sel_clamped;
            end
            if (r_state == S_PEND && w_term) begin
                r_cur_div <= r_pend_div;
            end
        end
    end

    assign div_ack = r_ack;
    assign clk_en  = r_clk_en;
    assign cur_div = r_cur_div;
    assign phase   = r_cnt;
    assign busy    = r_busy;

endmodule

// File: tb/tb_cpu_clk_en_sched.sv
// Self-checking bench for cpu_clk_en_sched: directed scenarios plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_cpu_clk_en_sched;

    localparam int W   = 4;
    localparam int DEF = 3;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         div_req = 1'b0;
    logic [W-1:0] div_sel = '0;
    logic         stall   = 1'b0;
    logic         div_ack;
    logic         clk_en;
    logic [W-1:0] cur_div;
    logic [W-1:0] phase;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    // model: position within period, ratio, handshake step (0 idle, 1 wait, 2 acked)
    int m_phase;
    int m_cur;
    int m_pend;
    int m_hs;
    int m_en;

    cpu_clk_en_sched #(.DIV_W(W), .DEF_DIV(DEF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div_req (div_req),
        .div_sel (div_sel),
        .div_ack (div_ack),
        .stall   (stall),
        .clk_en  (clk_en),
        .cur_div (cur_div),
        .phase   (phase),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cur   = DEF;
        m_pend  = 0;
        m_hs    = 0;
        m_en    = 0;
    endtask

    task automatic model_step();
        bit term;
        term = !stall && (m_phase + 1 == m_cur);
        m_en = term ? 1 : 0;
        if (!stall) m_phase = term ? 0 : m_phase + 1;
        case (m_hs)
            0: if (div_req) begin
                m_pend = (div_sel == '0) ? 1 : int'(div_sel);
                m_hs   = 1;
            end
            1: if (term) begin
                m_cur = m_pend;
                m_hs  = 2;
            end
            default: if (!div_req) m_hs = 0;
        endcase
    endtask

    task automatic check_all();
        chk("clk_en",  32'(clk_en),  32'(m_en));
        chk("phase",   32'(phase),   32'(m_phase));
        chk("cur_div", 32'(cur_div), 32'(m_cur));
        chk("div_ack", 32'(div_ack), 32'(m_hs == 2));
        chk("busy",    32'(busy),    32'(m_hs != 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ack(input int budget);
        int n;
        n = 0;
        while (!div_ack && n < budget) begin
            tick();
            n++;
        end
        chk("ack_within_budget", 32'(div_ack), 32'd1);
    endtask

    // full compliant switch to a ratio, leaving the FSM idle
    task automatic switch_to(input int sel);
        div_sel = W'(sel);
        div_req = 1'b1;
        tick();
        wait_ack(40);
        div_req = 1'b0;
        tick();
        chk("ack_drop", 32'(div_ack), 32'd0);
    endtask

    // cycles from now until the next strobe
    task automatic count_to_strobe(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!clk_en && n < 40);
    endtask

    initial begin
        int n;
        int acks;
        model_reset();

        #12;
        check_all();
        chk("reset_cur_div", 32'(cur_div), 32'(DEF));
        @(negedge clk);
        reset_n = 1'b1;

        tick();
        chk("boot_phase1", 32'(phase), 32'd1);
        tick();
        chk("boot_phase2", 32'(phase), 32'd2);
        chk("boot_en_low", 32'(clk_en), 32'd0);
        tick();
        chk("boot_strobe_edge3", 32'(clk_en), 32'd1);
        chk("boot_phase0", 32'(phase), 32'd0);

        // 3 -> 5 requested at phase 0
        div_sel = 4'd5;
        div_req = 1'b1;
        tick();
        chk("req_busy", 32'(busy), 32'd1);
        wait_ack(10);
        chk("switch_on_strobe", 32'(clk_en), 32'd1);
        chk("cur_div_5", 32'(cur_div), 32'd5);
        div_req = 1'b0;
        tick();
        chk("ack_fall", 32'(div_ack), 32'd0);
        n = 1;
        while (!clk_en && n < 40) begin
            tick();
            n++;
        end
        chk("period_5", 32'(n), 32'd5);

        // stall 4 cycles at phase 1 with ratio 3
        switch_to(3);
        n = 0;
        while (phase != 4'd1 && n < 10) begin
            tick();
            n++;
        end
        chk("reach_phase1", 32'(phase), 32'd1);
        stall = 1'b1;
        ticks(4);
        chk("stall_phase_hold", 32'(phase), 32'd1);
        stall = 1'b0;
        count_to_strobe(n);
        chk("stall_delay", 32'(n), 32'd2);
        count_to_strobe(n);
        chk("period_3_resume", 32'(n), 32'd3);

        // ratio 1, then 0 clamped to 1
        switch_to(1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("div1_en", 32'(clk_en), 32'd1);
        end
        switch_to(0);
        chk("clamp_cur_div", 32'(cur_div), 32'd1);
        tick();
        chk("div0_en", 32'(clk_en), 32'd1);

        // 15 -> 2 with stall held through PEND
        switch_to(15);
        stall   = 1'b1;
        div_sel = 4'd2;
        div_req = 1'b1;
        ticks(20);
        chk("no_ack_stalled", 32'(div_ack), 32'd0);
        chk("stalled_busy", 32'(busy), 32'd1);
        stall = 1'b0;
        wait_ack(16);
        chk("cur_div_2", 32'(cur_div), 32'd2);
        div_req = 1'b0;
        tick();

        // req dropped before ack: one-cycle ack
        div_sel = 4'd7;
        div_req = 1'b1;
        tick();
        div_req = 1'b0;
        div_sel = 4'd9;
        wait_ack(10);
        chk("viol_cur_div", 32'(cur_div), 32'd7);
        tick();
        chk("viol_ack_1cyc", 32'(div_ack), 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall   = ($urandom_range(0, 3) == 0);
            div_req = ($urandom_range(0, 2) != 0) ? div_req : ~div_req;
            div_sel = W'($urandom_range(0, 15));
            tick();
        end
        div_req = 1'b0;
        stall   = 1'b0;
        ticks(3);

        // async reset mid-PEND
        stall   = 1'b1;
        div_sel = 4'd9;
        div_req = 1'b1;
        ticks(2);
        chk("pend_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        div_req = 1'b0;
        stall   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (div_ack) acks++;
        end
        chk("no_ack_after_abort", 32'(acks), 32'd0);
        chk("abort_cur_div", 32'(cur_div), 32'(DEF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_clk_en_sched.md
# cpu_clk_en_sched

Clock-enable scheduler for the system clock divider. It generates a one-cycle `clk_en` strobe every N cycles of the master clock, with N selectable at run time. This covers, for example, the divide-by-3 4.77 MHz CPU rate and faster turbo ratios. Ratio changes use a four-phase req/ack handshake and take effect only at a period boundary, so no short or long strobe period is ever produced. A `stall` input freezes the divider for wait states.

## Interface
- `DIV_W`, default 4: width of the ratio and counter; maximum ratio is 2^DIV_W-1.
- `DEF_DIV`, default 3: ratio loaded at reset; must be in 1..2^DIV_W-1.

Ports:
- `clk` input, 1: master clock; the only clock.
- `reset_n` input, 1: asynchronous, active-low reset.
- `div_req` input, 1: ratio-change request, four-phase, held until `div_ack`.
- `div_sel` input, DIV_W: requested ratio, sampled when the request is accepted.
- `div_ack` output, 1: ratio change applied; high until `div_req` falls.
- `stall` input, 1: freeze the counter and suppress `clk_en`.
- `clk_en` output, 1: registered one-cycle enable strobe.
- `cur_div` output, DIV_W: ratio currently in effect.
- `phase` output, DIV_W: current counter value, 0..cur_div-1.
- `busy` output, 1: a ratio change is in progress (FSM state is not IDLE).

## Operation
- Counter `cnt` is DIV_W bits. The terminal condition is `term = (cnt == cur_div-1) && !stall`.
- When `stall` is 1: `cnt` holds and `clk_en` is driven 0.
- When `stall` is 0 and `term` is true: `cnt` becomes 0 and `clk_en` is driven 1.
- Otherwise: `cnt` becomes cnt+1 and `clk_en` is driven 0.
- Ratio 1 gives `clk_en` high on every non-stalled cycle.
- Ratio clamp: an accepted `div_sel` of 0 is stored as 1. No other values are altered.
- `pend_div` is a DIV_W-bit holding register for the accepted ratio.
- FSM states are IDLE, PEND and DONE.
  - IDLE: if `div_req` is 1, latch the clamped `div_sel` into `pend_div` and go to PEND.
  - PEND: on a `term` cycle, load `cur_div` from `pend_div`. That cycle's strobe still fires under the old ratio, and `cnt` wraps to 0. Then go to DONE.
  - PEND while stalled: the FSM waits indefinitely, since `term` cannot occur.
  - DONE: `div_ack` is 1. If `div_req` is 0, go to IDLE. `div_ack` falls in the same cycle the state becomes IDLE.
- Requesting a ratio equal to `cur_div` still follows the full PEND/DONE sequence.
- If `div_req` falls before `div_ack` (a protocol violation), the switch still completes. `div_ack` is then high for exactly one cycle in DONE.
- `div_sel` changes after acceptance are ignored until the next IDLE acceptance.
- `busy` is 1 in PEND and DONE.
- Reset (async assert, at any time including mid-PEND):
  - `cnt`, `clk_en`, `div_ack` and `busy` are 0.
  - `cur_div` is DEF_DIV and the FSM is in IDLE.
  - Any pending ratio is discarded.

## Timing
- All outputs are registered. `cur_div`, `phase` and `busy` are direct register outputs.
- After `reset_n` rises, `clk_en` goes high following rising edge DEF_DIV (the 3rd edge by default). It then repeats every `cur_div` non-stalled cycles.
- Stalled cycles extend the period one-for-one. No strobe is lost or duplicated.
- Request latency:
  - `div_req` is sampled on edge k, and the state is PEND after edge k.
  - The first `term` edge at or after k+1 updates `cur_div`, and `div_ack` goes high after that same edge.
  - The first new-ratio period is measured from that strobe.
- Worst-case switch latency, unstalled, is the old `cur_div` plus 1 cycles.
- `div_ack` falls one edge after `div_req` is sampled low.
- A new request is accepted no earlier than the edge after returning to IDLE.

## Test plan
- Reset with DEF_DIV=3 and no stall: `clk_en` pattern 0,0,1,0,0,1…; `phase` 1,2,0…; `cur_div`=3.
- With `cur_div`=3 and `phase`=0, request `div_sel`=5: strobe at the old boundary, then a period of 5 cycles; `div_ack` after that boundary; `div_ack` drops one cycle after `div_req` drops.
- Hold `stall` for 4 cycles at `phase`=1 with ratio 3: `phase` stays 1 and `clk_en` stays 0; the next strobe arrives exactly 4 cycles late; the period then resumes at 3.
- `div_sel`=1: `clk_en` stays high continuously. Then `div_sel`=0: `cur_div` reads 1, same behaviour.
- Ratio 15, request to 2 while `stall` is held through PEND: no ack while stalled; release `stall`, and the ack follows the next terminal.
- Assert `reset_n` low while in PEND: outputs return to reset values, `cur_div`=3, and no `div_ack` is ever issued for the aborted request.
